pipeline_hazard_ctrl: RTL and testbench

- Sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage load enables and synchronous flush strobes.
- Resolves three events: load-use hazards (one bubble), taken branches (two-stage flush) and variable-latency data-memory accesses (full-pipeline freeze with req/ready handshake and timeout).
- Sits beside the datapath; its enables and flushes drive the enable/clear inputs of every pipeline register.

---
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline sequencing: load-use bubble, branch flush, memory-wait freeze
module pipeline_hazard_ctrl #(
    parameter int REG_BITS    = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_uses_rs2,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_mem_read,
    input  logic                ex_branch_taken,
    input  logic                mem_access,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                pc_en,
    output logic                if_id_en,
    output logic                id_ex_en,
    output logic                ex_mem_en,
    output logic                mem_wb_en,
    output logic                if_id_flush,
    output logic                id_ex_flush,
    output logic                mem_timeout_err,
    output logic [CNT_W-1:0]    stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_q;

    logic load_use;
    logic mem_stall;

    assign load_use  = ex_mem_read && (ex_rd != '0) &&
                       ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    assign mem_stall = mem_access && !mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wait_d          = wait_q;
        mem_req         = 1'b0;
        pc_en           = 1'b0;
        if_id_en        = 1'b0;
        id_ex_en        = 1'b0;
        ex_mem_en       = 1'b0;
        mem_wb_en       = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        mem_timeout_err = 1'b0;
        // Outputs stay forced low for as long as reset is held, not just until the next edge.
        if (rst) begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        mem_req = 1'b1;
                        state_d = MEM_WAIT;
                        wait_d  = 8'd1;
                    end else begin
                        mem_req = mem_access;
                        if (ex_branch_taken) begin
                            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end else if (load_use) begin
                            id_ex_en    = 1'b1;
                            id_ex_flush = 1'b1;
                            ex_mem_en   = 1'b1;
                            mem_wb_en   = 1'b1;
                        end else begin
                            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                        end
                    end
                end
                MEM_WAIT: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                        state_d = RUN;
                        wait_d  = 8'd0;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = ERROR;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                ERROR: begin
                    mem_timeout_err = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    wait_d  = 8'd0;
                end
            endcase
        end
    end

    // Saturating count of frozen-PC cycles, including time spent in ERROR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed bench with cycle-by-cycle behavioural model for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int REG_BITS    = 5;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [REG_BITS-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic                id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic                mem_access = 1'b0, mem_ready = 1'b0;
    logic                mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic                if_id_flush, id_ex_flush, mem_timeout_err;
    logic [CNT_W-1:0]    stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_hazard_ctrl #(
        .REG_BITS(REG_BITS), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .mem_ready(mem_ready),
        .mem_req(mem_req), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_timeout_err(mem_timeout_err), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: m_stalled counts cycles already spent frozen on the current memory access.
    int m_stalled = 0;
    bit m_err     = 1'b0;
    int m_cnt     = 0;

    always @(negedge clk) begin
        logic [9:0] e;   // {req, pc, ifid, idex, exmem, memwb, fl_ifid, fl_idex, err, spare}
        bit lu;
        e  = '0;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        if (!rst) begin
            check("reset_outputs", {mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                                    if_id_flush, id_ex_flush, mem_timeout_err, 1'b0}, 0);
            check("reset_stall_count", stall_count, 0);
            m_stalled = 0;
            m_err     = 1'b0;
            m_cnt     = 0;
        end else begin
            if (m_err) begin
                e[1] = 1'b1;
            end else if (m_stalled > 0) begin
                e[9] = 1'b1;
                if (mem_ready) begin
                    e[8:4]    = 5'b11111;
                    m_stalled = 0;
                end else if (m_stalled + 1 == MEM_TIMEOUT) begin
                    m_err     = 1'b1;
                    m_stalled = 0;
                end else begin
                    m_stalled++;
                end
            end else if (mem_access && !mem_ready) begin
                e[9]      = 1'b1;
                m_stalled = 1;
            end else begin
                e[9] = mem_access;
                if (ex_branch_taken)  e[8:2] = 7'b1111111;
                else if (lu)          e[8:2] = 7'b0011101;
                else                  e[8:4] = 5'b11111;
            end
            check("outputs", {mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                              if_id_flush, id_ex_flush, mem_timeout_err, 1'b0}, int'(e));
            check("stall_count", stall_count, m_cnt);
            if (!e[8] && m_cnt < CNT_MAX) m_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_uses_rs2 = 0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_access = 0; mem_ready = 0;
    endtask

    initial begin
        #3;
        check("lit_reset_pc_en", pc_en, 0);
        check("lit_reset_mem_req", mem_req, 0);
        check("lit_reset_count", stall_count, 0);
        step(); step();
        rst = 1'b1;
        #1 check("lit_idle_pc_en", pc_en, 1);
        step();

        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
        #1;
        check("lit_lu_pc_en", pc_en, 0);
        check("lit_lu_if_id_en", if_id_en, 0);
        check("lit_lu_id_ex_flush", id_ex_flush, 1);
        check("lit_lu_ex_mem_en", ex_mem_en, 1);
        step(); clr();
        #1;
        check("lit_lu_after_pc_en", pc_en, 1);
        check("lit_lu_count", stall_count, 1);
        step();

        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
        #1 check("lit_x0_no_stall", pc_en, 1);
        step();
        ex_rd = 7; id_rs2 = 7; id_rs1 = 3; id_uses_rs2 = 0;
        #1 check("lit_rs2_unused", pc_en, 1);
        step();
        id_uses_rs2 = 1;
        #1 check("lit_rs2_used", pc_en, 0);
        step(); clr();
        #1 check("lit_count_2", stall_count, 2);

        ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; ex_branch_taken = 1;
        #1;
        check("lit_br_pc_en", pc_en, 1);
        check("lit_br_if_id_flush", if_id_flush, 1);
        check("lit_br_id_ex_flush", id_ex_flush, 1);
        step(); clr();
        #1 check("lit_br_count", stall_count, 2);

        mem_access = 1; mem_ready = 0; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lit_mw_pc_en", pc_en, 0);
            check("lit_mw_mem_req", mem_req, 1);
            step();
        end
        mem_ready = 1;
        #1;
        check("lit_mw_done_pc_en", pc_en, 1);
        check("lit_mw_done_flush", if_id_flush, 0);
        step(); clr();
        #1 check("lit_mw_count", stall_count, 5);

        mem_access = 1; mem_ready = 1;
        #1 check("lit_zero_wait_req", mem_req, 1);
        step(); clr();

        mem_access = 1; mem_ready = 0;
        repeat (4) step();
        #1;
        check("lit_to_err", mem_timeout_err, 1);
        check("lit_to_req", mem_req, 0);
        clr();
        repeat (3) step();
        check("lit_to_sticky", mem_timeout_err, 1);
        check("lit_to_count", stall_count, 12);
        rst = 1'b0;
        #1;
        check("lit_rst_err", mem_timeout_err, 0);
        check("lit_rst_count", stall_count, 0);
        step();
        rst = 1'b1;
        step();

        mem_access = 1; mem_ready = 0;
        step(); step();
        rst = 1'b0;
        #1;
        check("lit_abort_req", mem_req, 0);
        check("lit_abort_pc_en", pc_en, 0);
        check("lit_abort_mem_wb_en", mem_wb_en, 0);
        step();
        rst = 1'b1; clr();
        mem_access = 1; mem_ready = 1;
        #1 check("lit_resume_req", mem_req, 1);
        check("lit_resume_pc_en", pc_en, 1);
        step();

        mem_ready = 0;
        repeat (20) step();
        #1 check("lit_saturate", stall_count, CNT_MAX);
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
